// File: rtl/load_scoreboard_pkg.sv
// Shared core definitions: register address width and the hard-wired zero register.
package load_scoreboard_pkg;
    localparam int REG_ADDR_W = 5;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    localparam reg_addr_t X0 = '0;
endpackage

// File: rtl/load_scoreboard_match.sv
// One source-register hazard check against all outstanding loads plus the issuing load.
module sb_match
    import load_scoreboard_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd,
    input  logic [DEPTH-1:0]                 ent_vld,
    input  logic                             issue_fire,
    input  logic [REG_ADDR_W-1:0]            issue_rd,
    input  logic [REG_ADDR_W-1:0]            src,
    input  logic                             uses,
    output logic                             hit
);
    logic any_ent;

    always_comb begin
        any_ent = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && ent_rd[i] == src) any_ent = 1'b1;
        end
        // x0 is never a real dependency, even when a load targets it
        hit = uses && (src != X0) && (any_ent || (issue_fire && issue_rd == src));
    end
endmodule

// File: rtl/load_scoreboard.sv
// In-order scoreboard of outstanding bus loads; stalls decode on any source
// register still waiting for load data.
module load_scoreboard
    import load_scoreboard_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        issue_valid,
    input  logic [REG_ADDR_W-1:0]       issue_rd,
    output logic                        issue_ready,
    input  logic                        resp_valid,
    output logic                        resp_ready,
    output logic [REG_ADDR_W-1:0]       resp_rd,
    input  logic [REG_ADDR_W-1:0]       rs1,
    input  logic [REG_ADDR_W-1:0]       rs2,
    input  logic                        uses_rs1,
    input  logic                        uses_rs2,
    output logic                        hazard_stall,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        resp_error
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;
    logic [DEPTH-1:0]                 ent_vld;
    logic [PW-1:0]                    head, tail;
    logic [CW-1:0]                    cnt;
    logic                             full, empty, enq, deq;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    // Full refuses issue even if the head retires this cycle
    assign enq   = issue_valid && !full;
    assign deq   = resp_valid && !empty;

    assign issue_ready = !full;
    assign resp_ready  = !empty;
    assign resp_rd     = empty ? X0 : ent_rd[head];
    assign count       = cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_rd     <= '0;
            ent_vld    <= '0;
            head       <= '0;
            tail       <= '0;
            cnt        <= '0;
            resp_error <= 1'b0;
        end else begin
            if (enq) begin
                ent_rd[tail]  <= issue_rd;
                ent_vld[tail] <= 1'b1;
                tail          <= tail + PW'(1);
            end
            if (deq) begin
                ent_vld[head] <= 1'b0;
                head          <= head + PW'(1);
            end
            case ({enq, deq})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (resp_valid && empty) resp_error <= 1'b1;
        end
    end

    logic [1:0][REG_ADDR_W-1:0] srcs;
    logic [1:0]                 uses, hits;

    assign srcs = {rs2, rs1};
    assign uses = {uses_rs2, uses_rs1};

    for (genvar s = 0; s < 2; s++) begin : g_match
        sb_match #(.DEPTH(DEPTH)) u_match (
            .ent_rd     (ent_rd),
            .ent_vld    (ent_vld),
            .issue_fire (enq),
            .issue_rd   (issue_rd),
            .src        (srcs[s]),
            .uses       (uses[s]),
            .hit        (hits[s])
        );
    end

    assign hazard_stall = |hits;
endmodule

// File: doc/load_scoreboard.md
# load_scoreboard

Tracks register destinations of loads issued to the AXI data port but not yet returned, and raises the decode-stage stall for any instruction that reads such a register. The load-use detector only sees a load while it sits in EX. This block covers the multi-cycle window after issue, until the read response writes back. It sits between the EX/MEM issue point and the memory-response writeback path, and its stall is ORed into the decode stall.

## Interface
- DEPTH, 4: maximum outstanding loads; power of two, ≥2.
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- issue_valid  input  1  a load is sent to the bus this cycle.
- issue_rd  input  5  destination register of the issuing load.
- issue_ready  output  1  space available; `!full`.
- resp_valid  input  1  read data for the oldest outstanding load is present.
- resp_ready  output  1  `!empty`.
- resp_rd  output  5  destination of the oldest entry (head), for the writeback mux; 0 when empty.
- rs1, rs2  input  5  decode-stage source registers.
- uses_rs1, uses_rs2  input  1  decode instruction actually reads rs1/rs2.
- hazard_stall  output  1  decode must hold.
- count  output  $clog2(DEPTH)+1  outstanding loads.
- resp_error  output  1  sticky; set by `resp_valid` while empty.

## Operation
- In-order circular FIFO of DEPTH entries. Each entry holds a 5-bit rd and a valid bit. Head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Enqueue on `issue_valid && issue_ready`: write `issue_rd` at the tail and advance the tail.
  - Loads to x0 are enqueued to preserve response order, but never match a source.
- Dequeue on `resp_valid && resp_ready`: clear the head valid bit and advance the head.
- Simultaneous enqueue and dequeue: both occur and `count` is unchanged.
  - When full, the enqueue is still refused in that cycle: `issue_ready` does not depend on `resp_valid`.
- `issue_valid` while full is ignored and does not change state. The issuing pipeline must hold until `issue_ready` is high.
- `resp_valid` while empty is ignored except that it sets `resp_error`. Only reset clears `resp_error`.
- `hazard_stall` is combinational and is 1 if, for src in {rs1 if uses_rs1, rs2 if uses_rs2} with src≠0, either condition holds:
  - any valid entry has rd == src, including the head being dequeued this cycle (conservative; no bypass), or
  - `issue_valid && issue_ready && issue_rd == src`.
- If the same rd appears in several entries, the stall holds until the last matching entry dequeues.
- No flush input: issued loads always complete on the bus.

## Timing
- Reset values: all entries invalid, pointers 0, `count`=0, `issue_ready`=1, `resp_ready`=0, `resp_rd`=0, `hazard_stall`=0, `resp_error`=0.
- Reset takes priority over simultaneous issue and response in the same cycle. Reset mid-operation discards all entries.
- Entry visible in state one cycle after the issue edge; the same-cycle issue match covers the gap.
- A dequeue at edge N means `hazard_stall` for that rd drops in cycle N+1, giving one bubble after writeback.
- `resp_rd` is valid in the same cycle as the accepted `resp_valid`. It has no latency.
- `count` and `issue_ready` update on the edge following the handshake.

## Structure
- Shared core package holds `REG_ADDR_W`=5 and the `X0` constant. The decode stage already uses these; the package is the single source.
- Per-source match logic is duplicated for rs1 and rs2. Factor it into one sub-module, `sb_match` (DEPTH entries plus the issue port in, one hit out), instantiated twice.
- FIFO storage is inline; it is too small for a separate module.

## Test plan
- Reset, then issue rd=5 (cycle 1) → `count`=1. Decode with rs1=5, uses_rs1=1 → `hazard_stall`=1 in cycle 1 (same-cycle match) and thereafter. `resp_valid` at cycle 4 → `resp_rd`=5, stall=0 from cycle 5.
- Issue rd=0, then decode rs1=0 → stall=0. `resp_rd`=0 on the response and `count` returns to 0.
- Issue rd=3,7,3,9 with no responses → `count`=4, `issue_ready`=0. Fifth issue rd=11 is ignored. Decode rs2=3 (uses_rs2=1) stays stalled through two responses and clears after the third.
- Full FIFO with `issue_valid` and `resp_valid` in the same cycle → the head dequeues, the issue is refused, `count`=3. The next cycle's issue is accepted → `count`=4.
- `resp_valid` with `count`=0 → `resp_error`=1 and stays 1. `count` stays 0. Reset clears it.
- Three outstanding loads, reset asserted together with `issue_valid` → `count`=0, stall=0, `issue_ready`=1 next cycle. The pre-reset rd no longer stalls.
